// File: rtl/io_controller.sv
// io_controller: memory-mapped LEDs, switches, debounced buttons,
// seven-segment digits and a prescaled compare timer.
module io_controller #(
  parameter int DATA_SIZE       = 16,
  parameter int ADDRESS_SIZE    = 12,
  parameter int NUM_LEDS        = 10,
  parameter int NUM_SWITCHES    = 10,
  parameter int NUM_BUTTONS     = 4,
  parameter int NUM_HEX         = 4,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PRESCALE        = 50000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [ADDRESS_SIZE-1:0]   a_address,
  input  logic [DATA_SIZE-1:0]      a_writeData,
  input  logic                      a_we,
  output logic [DATA_SIZE-1:0]      a_out,
  input  logic [ADDRESS_SIZE-1:0]   b_address,
  output logic [DATA_SIZE-1:0]      b_out,
  input  logic [NUM_SWITCHES-1:0]   switches,
  input  logic [NUM_BUTTONS-1:0]    pushButtons,
  output logic [NUM_LEDS-1:0]       leds,
  output logic [7*NUM_HEX-1:0]      hex_segments,
  output logic                      irq
);

  localparam int DS = DATA_SIZE;
  localparam int AW = ADDRESS_SIZE;
  localparam int NB = NUM_BUTTONS;
  localparam int NMAP = 16;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PSC_MAX =
    PW'(PRESCALE - 1);

  localparam logic [3:0] O_LED  = 4'd0;
  localparam logic [3:0] O_PEND = 4'd3;
  localparam logic [3:0] O_TCNT = 4'd4;
  localparam logic [3:0] O_TCMP = 4'd5;
  localparam logic [3:0] O_TCTL = 4'd6;

  // Offset counts down from the top word, so it is the inverted address.
  logic          a_io, b_io;
  logic [AW-1:0] a_off, b_off;
  logic          a_low, b_low;
  logic [3:0]    a_idx, b_idx;
  logic          a_wr;

  assign a_io  = a_address[AW-1 -: 2] == 2'b11;
  assign b_io  = b_address[AW-1 -: 2] == 2'b11;
  assign a_off = ~a_address;
  assign b_off = ~b_address;
  assign a_low = a_off[AW-1:4] == '0;
  assign b_low = b_off[AW-1:4] == '0;
  assign a_idx = a_off[3:0];
  assign b_idx = b_off[3:0];
  assign a_wr  = a_we & a_io & a_low;

  logic               wr_led, wr_pend;
  logic               wr_tcnt, wr_tcmp, wr_tctl;
  logic [NUM_HEX-1:0] wr_hex;

  assign wr_led  = a_wr && (a_idx == O_LED);
  assign wr_pend = a_wr && (a_idx == O_PEND);
  assign wr_tcnt = a_wr && (a_idx == O_TCNT);
  assign wr_tcmp = a_wr && (a_idx == O_TCMP);
  assign wr_tctl = a_wr && (a_idx == O_TCTL);

  always_comb begin
    wr_hex = '0;
    for (int i = 0; i < NUM_HEX; i++)
      wr_hex[i] = a_wr && (a_idx == 4'(8 + i));
  end

  logic [NUM_LEDS-1:0]     led_q;
  logic [NUM_SWITCHES-1:0] sw_s1, sw_s2;
  logic [NB-1:0]           btn_s1, btn_s2;
  logic [NB-1:0]           btn_norm, btn_lvl;
  logic [NB-1:0]           btn_flip, pend_set;
  logic [NB-1:0]           pend_q, pend_clr;
  logic [CW-1:0]           btn_cnt [NB];
  logic [DS-1:0]           tcnt_q, tcmp_q;
  logic                    run_q, mie_q, bie_q;
  logic                    match_q, match_set;
  logic [PW-1:0]           psc_q;
  logic                    tick, t_hit;
  logic [6:0]              hex_q [NUM_HEX];

  assign btn_norm =
    (BTN_ACTIVE_LOW != 0) ? ~btn_s2 : btn_s2;

  always_comb begin
    btn_flip = '0;
    for (int i = 0; i < NB; i++)
      btn_flip[i] = (btn_norm[i] != btn_lvl[i])
                 && (btn_cnt[i] == CNT_MAX);
  end

  assign pend_set = btn_flip & btn_norm;
  assign pend_clr =
    wr_pend ? a_writeData[NB-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      btn_lvl <= '0;
      for (int i = 0; i < NB; i++)
        btn_cnt[i] <= '0;
    end else begin
      btn_s1 <= pushButtons;
      btn_s2 <= btn_s1;
      for (int i = 0; i < NB; i++) begin
        if (btn_norm[i] == btn_lvl[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_flip[i]) begin
          btn_lvl[i] <= btn_norm[i];
          btn_cnt[i] <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + CW'(1);
        end
      end
    end
  end

  // A CPU load of TCNT swallows a coincident tick entirely.
  assign tick      = run_q && (psc_q == PSC_MAX);
  assign t_hit     = tcnt_q == tcmp_q;
  assign match_set = tick && t_hit && !wr_tcnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      led_q   <= '0;
      pend_q  <= '0;
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      psc_q   <= '0;
      run_q   <= 1'b0;
      mie_q   <= 1'b0;
      bie_q   <= 1'b0;
      match_q <= 1'b0;
      irq     <= 1'b0;
      for (int i = 0; i < NUM_HEX; i++)
        hex_q[i] <= '0;
    end else begin
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      if (wr_led)
        led_q <= a_writeData[NUM_LEDS-1:0];
      if (wr_tcmp)
        tcmp_q <= a_writeData;
      if (wr_tctl)
        {bie_q, mie_q, run_q} <= a_writeData[2:0];
      match_q <= (match_q
                 & ~(wr_tctl & a_writeData[8]))
               | match_set;
      if (wr_tcnt) begin
        tcnt_q <= a_writeData;
        psc_q  <= '0;
      end else if (tick) begin
        psc_q  <= '0;
        tcnt_q <= t_hit ? '0 : tcnt_q + DS'(1);
      end else if (run_q) begin
        psc_q <= psc_q + PW'(1);
      end
      for (int i = 0; i < NUM_HEX; i++)
        if (wr_hex[i])
          hex_q[i] <= a_writeData[6:0];
      irq <= (match_q & mie_q)
           | ((|pend_q) & bie_q);
    end
  end

  logic [DS-1:0] map   [NMAP];
  logic [DS-1:0] a_map [NMAP];
  logic [DS-1:0] a_rd, b_rd;

  always_comb begin
    for (int i = 0; i < NMAP; i++)
      map[i] = '0;
    map[0][NUM_LEDS-1:0]     = led_q;
    map[1][NUM_SWITCHES-1:0] = sw_s2;
    map[2][NB-1:0]           = btn_lvl;
    map[3][NB-1:0]           = pend_q;
    map[4]                   = tcnt_q;
    map[5]                   = tcmp_q;
    map[6][2:0]              = {bie_q, mie_q, run_q};
    map[6][8]                = match_q;
    for (int i = 0; i < NUM_HEX; i++)
      map[8+i][6:0] = hex_q[i];
  end

  // Port a sees freshly written R/W fields; W1C bits stay pre-write.
  always_comb begin
    a_map = map;
    if (wr_led) begin
      a_map[0] = '0;
      a_map[0][NUM_LEDS-1:0] =
        a_writeData[NUM_LEDS-1:0];
    end
    if (wr_tcnt)
      a_map[4] = a_writeData;
    if (wr_tcmp)
      a_map[5] = a_writeData;
    if (wr_tctl)
      a_map[6][2:0] = a_writeData[2:0];
    for (int i = 0; i < NUM_HEX; i++)
      if (wr_hex[i])
        a_map[8+i][6:0] = a_writeData[6:0];
  end

  assign a_rd = a_low ? a_map[a_idx] : '0;
  assign b_rd = b_low ? map[b_idx] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_out <= '0;
      b_out <= '0;
    end else begin
      if (a_io)
        a_out <= a_rd;
      if (b_io)
        b_out <= b_rd;
    end
  end

  assign leds = led_q;

  always_comb begin
    hex_segments = '0;
    for (int i = 0; i < NUM_HEX; i++)
      hex_segments[7*i +: 7] = hex_q[i];
  end

endmodule

// File: tb/tb_io_controller.sv
// tb_io_controller: directed scoreboard bench for io_controller
// with short debounce and prescale settings.
module tb_io_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] a_address, b_address;
  logic [15:0] a_writeData;
  logic        a_we;
  logic [15:0] a_out, b_out;
  logic [9:0]  switches, leds;
  logic [3:0]  pushButtons;
  logic [27:0] hex_segments;
  logic        irq;

  always #5 clk = ~clk;

  io_controller #(
    .DEBOUNCE_CYCLES(4),
    .PRESCALE(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .a_address(a_address),
    .a_writeData(a_writeData),
    .a_we(a_we),
    .a_out(a_out),
    .b_address(b_address),
    .b_out(b_out),
    .switches(switches),
    .pushButtons(pushButtons),
    .leds(leds),
    .hex_segments(hex_segments),
    .irq(irq)
  );

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  bit   a_due, b_due;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] tc_exp [10] =
    '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2,
      16'd2, 16'd3, 16'd3, 16'd0, 16'd0};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (a_due) begin
      e = qa.pop_front();
      chk(e.tag, {16'h0, a_out}, {16'h0, e.v});
    end
    if (b_due) begin
      e = qb.pop_front();
      chk(e.tag, {16'h0, b_out}, {16'h0, e.v});
    end
    a_due     = 1'b0;
    b_due     = 1'b0;
    a_we      = 1'b0;
    a_address = 12'h000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step();
  endtask

  task automatic push_a(input string tag,
                        input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    qa.push_back(e);
    a_due = 1'b1;
  endtask

  task automatic rd_a(input logic [11:0] ad,
                      input string tag,
                      input logic [15:0] v);
    a_address = ad;
    a_we      = 1'b0;
    push_a(tag, v);
  endtask

  task automatic wr_a(input logic [11:0] ad,
                      input logic [15:0] d);
    a_address   = ad;
    a_writeData = d;
    a_we        = 1'b1;
  endtask

  task automatic rd_b(input logic [11:0] ad,
                      input string tag,
                      input logic [15:0] v);
    exp_t e;
    b_address = ad;
    e.tag = tag;
    e.v   = v;
    qb.push_back(e);
    b_due = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    a_address   = 12'h000;
    b_address   = 12'h000;
    a_writeData = 16'h0;
    a_we        = 1'b0;
    switches    = 10'h0;
    pushButtons = 4'hF;
    idle(2);
    chk("rst_leds", {22'h0, leds}, 32'h0);
    chk("rst_hex", {4'h0, hex_segments}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_a_out", {16'h0, a_out}, 32'h0);
    chk("rst_b_out", {16'h0, b_out}, 32'h0);
    reset_n = 1'b1;

    wr_a(12'hFFF, 16'h03FF);
    push_a("led_rdw", 16'h03FF);
    step();
    chk("led_pin", {22'h0, leds}, 32'h3FF);
    rd_a(12'hFFF, "led_rd", 16'h03FF);
    step();

    switches = 10'h2A5;
    for (int i = 0; i < 4; i++) begin
      rd_a(12'hFFE, $sformatf("sw_sync%0d", i),
           (i >= 2) ? 16'h02A5 : 16'h0000);
      step();
    end

    pushButtons = 4'hD;
    idle(3);
    pushButtons = 4'hF;
    idle(8);
    rd_a(12'hFFC, "glitch_pend", 16'h0000);
    rd_b(12'hFFD, "glitch_btn", 16'h0000);
    step();

    pushButtons = 4'hD;
    idle(8);
    rd_a(12'hFFD, "held_btn", 16'h0002);
    rd_b(12'hFFC, "held_pend", 16'h0002);
    step();
    pushButtons = 4'hF;
    idle(10);
    rd_a(12'hFFD, "release_btn", 16'h0000);
    step();

    wr_a(12'hFFC, 16'h0002);
    push_a("w1c_rdw", 16'h0002);
    rd_b(12'hFFC, "w1c_b_pre", 16'h0002);
    step();
    rd_a(12'hFFC, "w1c_cleared", 16'h0000);
    step();

    pushButtons = 4'hD;
    idle(5);
    wr_a(12'hFFC, 16'h0002);
    push_a("collide_rdw", 16'h0000);
    step();
    rd_a(12'hFFC, "collide_set_wins", 16'h0002);
    step();
    pushButtons = 4'hF;
    idle(10);

    wr_a(12'hFF9, 16'h0004);
    push_a("tctl_bie_rdw", 16'h0004);
    step();
    step();
    chk("btn_irq_on", {31'h0, irq}, 32'h1);
    wr_a(12'hFFC, 16'h0002);
    step();
    step();
    chk("btn_irq_off", {31'h0, irq}, 32'h0);
    wr_a(12'hFF9, 16'h0000);
    step();

    wr_a(12'hFFA, 16'h0003);
    step();
    wr_a(12'hFFB, 16'h0000);
    step();
    wr_a(12'hFF9, 16'h0003);
    step();
    for (int k = 1; k <= 10; k++) begin
      rd_b(12'hFFB, $sformatf("tcnt%0d", k),
           tc_exp[k-1]);
      if (k == 9)
        rd_a(12'hFF9, "match_flag", 16'h0103);
      step();
      chk($sformatf("timer_irq%0d", k),
          {31'h0, irq}, (k >= 9) ? 32'h1 : 32'h0);
    end

    wr_a(12'hFF9, 16'h0100);
    push_a("tctl_w1c_rdw", 16'h0100);
    step();
    chk("irq_still", {31'h0, irq}, 32'h1);
    rd_a(12'hFF9, "tctl_clr", 16'h0000);
    step();
    chk("irq_drop", {31'h0, irq}, 32'h0);

    wr_a(12'hFFB, 16'h0005);
    step();
    wr_a(12'hFF9, 16'h0001);
    step();
    step();
    wr_a(12'hFFB, 16'h00FF);
    push_a("tcnt_wr_tick", 16'h00FF);
    step();
    rd_b(12'hFFB, "tcnt_ff_a", 16'h00FF);
    step();
    rd_b(12'hFFB, "tcnt_ff_b", 16'h00FF);
    step();
    rd_b(12'hFFB, "tcnt_next", 16'h0100);
    step();
    wr_a(12'hFF9, 16'h0000);
    step();

    wr_a(12'hFF7, 16'h007F);
    push_a("hex0_rdw", 16'h007F);
    rd_b(12'hFF7, "hex0_b_old", 16'h0000);
    step();
    chk("hex0_pin", {4'h0, hex_segments}, 32'h7F);
    rd_b(12'hFF7, "hex0_b_new", 16'h007F);
    step();
    wr_a(12'hFF4, 16'h0055);
    step();
    chk("hex3_pin", {4'h0, hex_segments},
        (32'h55 << 21) | 32'h7F);
    rd_a(12'hFF4, "hex3_rd", 16'h0055);
    step();
    rd_a(12'hABC, "out_of_io_hold", 16'h0055);
    step();
    wr_a(12'h3FF, 16'h0000);
    step();
    chk("out_of_io_wr", {22'h0, leds}, 32'h3FF);
    rd_a(12'hFF8, "unmapped7", 16'h0000);
    step();
    rd_a(12'hFF3, "unmapped12", 16'h0000);
    step();

    reset_n = 1'b0;
    step();
    chk("rst2_leds", {22'h0, leds}, 32'h0);
    chk("rst2_hex", {4'h0, hex_segments}, 32'h0);
    chk("rst2_a_out", {16'h0, a_out}, 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
